// File: rtl/multi_intr_controller_if.sv
// Endpoint-side interrupt handshake: request/ready, legacy message type and MSI vector.
interface multi_intr_controller_if #(
   parameter int unsigned C_VEC_W = 2
);
   logic               INTR_MSI_RDY;
   logic               INTR_MSI_REQUEST;
   logic               CFG_INTERRUPT_ASSERT;
   logic [C_VEC_W-1:0] INTR_MSI_VECTOR;

   modport master (
      input  INTR_MSI_RDY,
      output INTR_MSI_REQUEST,
      output CFG_INTERRUPT_ASSERT,
      output INTR_MSI_VECTOR
   );

   modport slave (
      output INTR_MSI_RDY,
      input  INTR_MSI_REQUEST,
      input  CFG_INTERRUPT_ASSERT,
      input  INTR_MSI_VECTOR
   );
endinterface

// File: rtl/multi_intr_controller.sv
// Multi-channel interrupt controller: coalesces per-channel requests and issues
// round-robin MSI sends or legacy assert/deassert message pairs.
module multi_intr_controller #(
   parameter int unsigned C_NUM_CHNL = 4,
   parameter int unsigned C_HOLDOFF  = 0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [C_NUM_CHNL-1:0] INTR,
   input  logic [C_NUM_CHNL-1:0] INTR_CLR,
   output logic [C_NUM_CHNL-1:0] INTR_DONE,
   output logic [C_NUM_CHNL-1:0] INTR_PENDING,
   input  logic                  CONFIG_INTERRUPT_MSIENABLE,
   input  logic [2:0]            CONFIG_INTERRUPT_MMENABLE,
   multi_intr_controller_if.master msi
);

   localparam int unsigned C_VEC_W = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1;
   localparam int unsigned C_HO_W  = 10;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_MSI_REQ      = 3'd1,
      S_HOLDOFF      = 3'd2,
      S_LEG_ASSERT   = 3'd3,
      S_LEG_WAIT     = 3'd4,
      S_LEG_DEASSERT = 3'd5
   } state_t;

   state_t                r_state;
   logic [C_NUM_CHNL-1:0] r_pending;
   logic [C_NUM_CHNL-1:0] r_done;
   logic [C_VEC_W-1:0]    r_ptr;
   logic [C_VEC_W-1:0]    r_winner;
   logic [C_VEC_W-1:0]    r_vec;
   logic [C_HO_W-1:0]     r_hold_cnt;
   logic                  r_req;
   logic                  r_assert;
   logic                  r_msi_mode;

   logic [C_VEC_W-1:0]    w_win;
   logic [C_VEC_W-1:0]    w_vec;
   logic [31:0]           w_lim;
   logic                  w_acc;
   logic [C_NUM_CHNL-1:0] w_msi_clr;
   logic [C_NUM_CHNL-1:0] w_leg_clr;
   logic [C_NUM_CHNL-1:0] w_clr;
   logic [C_NUM_CHNL-1:0] w_pend_nxt;

   // Round-robin pick: the pending channel closest after the last grant wins.
   always_comb begin
      w_win = r_ptr;
      for (int unsigned k = C_NUM_CHNL; k >= 1; k--) begin
         for (int unsigned i = 0; i < C_NUM_CHNL; i++) begin
            if (r_pending[i] && (i == ((32'(r_ptr) + k) % C_NUM_CHNL))) begin
               w_win = C_VEC_W'(i);
            end
         end
      end
   end

   // Vector clamps to the highest vector the host granted.
   always_comb begin
      w_lim = (32'd1 << CONFIG_INTERRUPT_MMENABLE) - 32'd1;
      w_vec = (32'(w_win) < w_lim) ? w_win : C_VEC_W'(w_lim);
   end

   // A new request on the same edge as its clear keeps the channel pending.
   always_comb begin
      w_acc      = (r_state == S_MSI_REQ) && r_req && msi.INTR_MSI_RDY;
      w_msi_clr  = w_acc ? (C_NUM_CHNL'(1) << r_winner) : '0;
      w_leg_clr  = ((r_state == S_LEG_WAIT) && !r_msi_mode) ? (INTR_CLR & r_pending) : '0;
      w_clr      = w_msi_clr | w_leg_clr;
      w_pend_nxt = (r_pending & ~w_clr) | INTR;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_pending  <= '0;
         r_done     <= '0;
         r_ptr      <= C_VEC_W'(C_NUM_CHNL - 1);
         r_winner   <= '0;
         r_vec      <= '0;
         r_hold_cnt <= '0;
         r_req      <= 1'b0;
         r_assert   <= 1'b0;
         r_msi_mode <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_done    <= w_clr;
         case (r_state)
            S_IDLE: begin
               if (|r_pending) begin
                  r_msi_mode <= CONFIG_INTERRUPT_MSIENABLE;
                  r_req      <= 1'b1;
                  if (CONFIG_INTERRUPT_MSIENABLE) begin
                     r_winner <= w_win;
                     r_ptr    <= w_win;
                     r_vec    <= w_vec;
                     r_assert <= 1'b0;
                     r_state  <= S_MSI_REQ;
                  end else begin
                     r_vec    <= '0;
                     r_assert <= 1'b1;
                     r_state  <= S_LEG_ASSERT;
                  end
               end
            end
            S_MSI_REQ: begin
               if (w_acc) begin
                  r_req <= 1'b0;
                  if (C_HOLDOFF > 0) begin
                     r_hold_cnt <= C_HO_W'(C_HOLDOFF - 1);
                     r_state    <= S_HOLDOFF;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_HOLDOFF: begin
               if (r_hold_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt - C_HO_W'(1);
               end
            end
            S_LEG_ASSERT: begin
               if (r_req && msi.INTR_MSI_RDY) begin
                  r_req   <= 1'b0;
                  r_state <= S_LEG_WAIT;
               end
            end
            S_LEG_WAIT: begin
               if (w_pend_nxt == '0) begin
                  r_req    <= 1'b1;
                  r_assert <= 1'b0;
                  r_state  <= S_LEG_DEASSERT;
               end
            end
            S_LEG_DEASSERT: begin
               if (r_req && msi.INTR_MSI_RDY) begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_req    <= 1'b0;
               r_assert <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign INTR_DONE                = r_done;
   assign INTR_PENDING             = r_pending;
   assign msi.INTR_MSI_REQUEST     = r_req;
   assign msi.CFG_INTERRUPT_ASSERT = r_assert;
   assign msi.INTR_MSI_VECTOR      = r_vec;

endmodule

// File: tb/tb_multi_intr_controller.sv
// Bench for multi_intr_controller: directed MSI/legacy/reset scenarios, then
// randomized MSI traffic against a transaction-level reference model.
module tb_multi_intr_controller;

   localparam int unsigned N  = 4;
   localparam int unsigned HO = 8;
   localparam int unsigned VW = 2;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [N-1:0]  INTR;
   logic [N-1:0]  INTR_CLR;
   logic [N-1:0]  INTR_DONE;
   logic [N-1:0]  INTR_PENDING;
   logic          MSIEN;
   logic [2:0]    MMEN;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   multi_intr_controller_if #(.C_VEC_W(VW)) msi_if ();

   multi_intr_controller #(.C_NUM_CHNL(N), .C_HOLDOFF(HO)) dut (
      .CLK                        (CLK),
      .RST_N                      (RST_N),
      .INTR                       (INTR),
      .INTR_CLR                   (INTR_CLR),
      .INTR_DONE                  (INTR_DONE),
      .INTR_PENDING               (INTR_PENDING),
      .CONFIG_INTERRUPT_MSIENABLE (MSIEN),
      .CONFIG_INTERRUPT_MMENABLE  (MMEN),
      .msi                        (msi_if)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (msi_if.INTR_MSI_REQUEST !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk("req_seen", msi_if.INTR_MSI_REQUEST, 1);
   endtask

   // Reference round-robin: first pending channel after the last grant.
   function automatic int rr(input logic [N-1:0] p, input int ptr);
      for (int k = 1; k <= int'(N); k++) begin
         if (p[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
      end
      return 0;
   endfunction

   function automatic logic [VW-1:0] clamp(input int w, input logic [2:0] mm);
      int lim;
      lim = (1 << mm) - 1;
      return VW'((w < lim) ? w : lim);
   endfunction

   initial begin
      int            n;
      logic [N-1:0]  pend;
      logic [N-1:0]  new_pend;
      logic [N-1:0]  exp_done;
      logic [VW-1:0] vec_pre;
      logic          req_pre;
      logic          acc;
      int            ptr;
      int            cur_win;
      int            acc_cyc;
      int            w;

      RST_N = 1'b0; INTR = '0; INTR_CLR = '0; MSIEN = 1'b1; MMEN = 3'd2;
      msi_if.INTR_MSI_RDY = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_req", msi_if.INTR_MSI_REQUEST, 0);
      chk("rst_assert", msi_if.CFG_INTERRUPT_ASSERT, 0);
      chk("rst_vec", msi_if.INTR_MSI_VECTOR, 0);
      chk("rst_done", INTR_DONE, 0);
      chk("rst_pend", INTR_PENDING, 0);
      RST_N = 1'b1;
      tick();

      // Single MSI send: channel 0 first, request two edges after the pulse.
      INTR = 4'b0001; tick(); INTR = '0;
      chk("m1_pend", INTR_PENDING, 4'b0001);
      chk("m1_req_early", msi_if.INTR_MSI_REQUEST, 0);
      tick();
      chk("m1_req", msi_if.INTR_MSI_REQUEST, 1);
      chk("m1_vec", msi_if.INTR_MSI_VECTOR, 0);
      chk("m1_assert", msi_if.CFG_INTERRUPT_ASSERT, 0);
      tick();
      chk("m1_done", INTR_DONE, 4'b0001);
      chk("m1_req_drop", msi_if.INTR_MSI_REQUEST, 0);
      chk("m1_pend_clr", INTR_PENDING, 0);
      tick();
      chk("m1_done_pulse", INTR_DONE, 0);
      repeat (12) tick();

      // Two simultaneous channels, vectors clamped to 1.
      MMEN = 3'd1;
      INTR = 4'b1100; tick(); INTR = '0;
      tick();
      chk("m2_pend0", INTR_PENDING, 4'b1100);
      chk("m2_vec_a", msi_if.INTR_MSI_VECTOR, 1);
      tick();
      chk("m2_done_a", INTR_DONE, 4'b0100);
      chk("m2_pend1", INTR_PENDING, 4'b1000);
      wait_req(20, n);
      chk("m2_gap", n >= int'(HO), 1);
      chk("m2_vec_b", msi_if.INTR_MSI_VECTOR, 1);
      tick();
      chk("m2_done_b", INTR_DONE, 4'b1000);
      chk("m2_pend2", INTR_PENDING, 0);
      repeat (12) tick();

      // Stalled ready: request and vector stay put; holdoff spaces the next send.
      MMEN = 3'd2; msi_if.INTR_MSI_RDY = 1'b0;
      INTR = 4'b0110; tick(); INTR = '0;
      wait_req(5, n);
      chk("m3_vec_a", msi_if.INTR_MSI_VECTOR, 1);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("m3_stall_req", msi_if.INTR_MSI_REQUEST, 1);
         chk("m3_stall_vec", msi_if.INTR_MSI_VECTOR, 1);
      end
      msi_if.INTR_MSI_RDY = 1'b1;
      tick();
      chk("m3_done_a", INTR_DONE, 4'b0010);
      wait_req(20, n);
      chk("m3_gap", n >= int'(HO), 1);
      chk("m3_vec_b", msi_if.INTR_MSI_VECTOR, 2);
      tick();
      chk("m3_done_b", INTR_DONE, 4'b0100);
      repeat (12) tick();

      // Legacy assert, partial clear, final clear then deassert; mode flip ignored.
      MSIEN = 1'b0; msi_if.INTR_MSI_RDY = 1'b0;
      INTR = 4'b0011; tick(); INTR = '0;
      tick();
      chk("l1_req", msi_if.INTR_MSI_REQUEST, 1);
      chk("l1_assert", msi_if.CFG_INTERRUPT_ASSERT, 1);
      msi_if.INTR_MSI_RDY = 1'b1; tick(); msi_if.INTR_MSI_RDY = 1'b0;
      chk("l1_wait_req", msi_if.INTR_MSI_REQUEST, 0);
      chk("l1_wait_assert", msi_if.CFG_INTERRUPT_ASSERT, 1);
      MSIEN = 1'b1;
      INTR_CLR = 4'b0001; tick(); INTR_CLR = '0;
      chk("l1_done_a", INTR_DONE, 4'b0001);
      chk("l1_pend_a", INTR_PENDING, 4'b0010);
      chk("l1_still_assert", msi_if.CFG_INTERRUPT_ASSERT, 1);
      chk("l1_no_req", msi_if.INTR_MSI_REQUEST, 0);
      INTR_CLR = 4'b0010; tick(); INTR_CLR = '0;
      chk("l1_done_b", INTR_DONE, 4'b0010);
      chk("l1_pend_b", INTR_PENDING, 0);
      chk("l1_deassert_req", msi_if.INTR_MSI_REQUEST, 1);
      chk("l1_deassert_type", msi_if.CFG_INTERRUPT_ASSERT, 0);
      msi_if.INTR_MSI_RDY = 1'b1; tick();
      MSIEN = 1'b0;
      chk("l1_idle_req", msi_if.INTR_MSI_REQUEST, 0);
      tick();
      chk("l1_idle_stay", msi_if.INTR_MSI_REQUEST, 0);

      // Set and clear of the same channel in the wait phase keeps it pending.
      INTR = 4'b0011; tick(); INTR = '0;
      tick(); tick();
      chk("l2_wait_assert", msi_if.CFG_INTERRUPT_ASSERT, 1);
      msi_if.INTR_MSI_RDY = 1'b0;
      INTR = 4'b0010; INTR_CLR = 4'b0010; tick(); INTR = '0; INTR_CLR = '0;
      chk("l2_pend_kept", INTR_PENDING, 4'b0011);
      chk("l2_no_req", msi_if.INTR_MSI_REQUEST, 0);
      INTR_CLR = 4'b0001; tick(); INTR_CLR = '0;
      chk("l2_pend_b", INTR_PENDING, 4'b0010);
      chk("l2_done_a", INTR_DONE, 4'b0001);
      tick();
      chk("l2_no_deassert", msi_if.INTR_MSI_REQUEST, 0);
      chk("l2_assert_held", msi_if.CFG_INTERRUPT_ASSERT, 1);
      INTR_CLR = 4'b0010; tick(); INTR_CLR = '0;
      chk("l2_deassert", msi_if.INTR_MSI_REQUEST, 1);
      chk("l2_deassert_type", msi_if.CFG_INTERRUPT_ASSERT, 0);
      msi_if.INTR_MSI_RDY = 1'b1; tick();
      chk("l2_idle", msi_if.INTR_MSI_REQUEST, 0);

      // Reset while a request is outstanding.
      MSIEN = 1'b1; MMEN = 3'd2; msi_if.INTR_MSI_RDY = 1'b0;
      INTR = 4'b0011; tick(); INTR = '0;
      wait_req(5, n);
      #2 RST_N = 1'b0;
      #1;
      chk("r_req", msi_if.INTR_MSI_REQUEST, 0);
      chk("r_assert", msi_if.CFG_INTERRUPT_ASSERT, 0);
      chk("r_vec", msi_if.INTR_MSI_VECTOR, 0);
      chk("r_done", INTR_DONE, 0);
      chk("r_pend", INTR_PENDING, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      msi_if.INTR_MSI_RDY = 1'b1;
      for (int s = 0; s < 6; s++) begin
         tick();
         chk("r_quiet", msi_if.INTR_MSI_REQUEST, 0);
      end
      chk("r_pend_after", INTR_PENDING, 0);

      // Randomized MSI traffic; legacy clears are thrown in and must be ignored.
      MMEN = 3'($urandom_range(0, 3));
      pend = '0; ptr = int'(N) - 1; cur_win = 0; acc_cyc = -1000;
      for (int it = 0; it < 600; it++) begin
         for (int b = 0; b < int'(N); b++) INTR[b] = ($urandom_range(0, 9) == 0);
         INTR_CLR = N'($urandom);
         msi_if.INTR_MSI_RDY = 1'($urandom_range(0, 1));
         req_pre  = msi_if.INTR_MSI_REQUEST;
         vec_pre  = msi_if.INTR_MSI_VECTOR;
         acc      = req_pre & msi_if.INTR_MSI_RDY;
         new_pend = pend;
         exp_done = '0;
         if (acc) begin
            new_pend[cur_win] = 1'b0;
            exp_done[cur_win] = 1'b1;
         end
         new_pend = new_pend | INTR;
         tick();
         if (acc) acc_cyc = cyc;
         chk("rnd_pend", INTR_PENDING, new_pend);
         chk("rnd_done", INTR_DONE, exp_done);
         if (msi_if.INTR_MSI_REQUEST === 1'b1 && req_pre === 1'b0) begin
            chk("rnd_req_nonempty", pend != '0, 1);
            w = rr(pend, ptr);
            chk("rnd_vec", msi_if.INTR_MSI_VECTOR, clamp(w, MMEN));
            chk("rnd_gap", (cyc - acc_cyc) >= int'(HO), 1);
            ptr = w;
            cur_win = w;
         end else if (msi_if.INTR_MSI_REQUEST === 1'b1 && req_pre === 1'b1) begin
            chk("rnd_vec_hold", msi_if.INTR_MSI_VECTOR, vec_pre);
         end
         pend = new_pend;
      end
      INTR = '0; INTR_CLR = '0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
